matrix_result_display: RTL and testbench

MATRIX_RESULT_DISPLAY -- requirements
Module: matrix_result_display

---
 rtl/matrix_result_display.sv | 160 ++++++++++++++++
 tb/tb_matrix_result_display.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/matrix_result_display.sv
// rtl/matrix_result_display.sv - seven-segment walker for a packed 2x2 signed product matrix
// Optional build macro MRD_LOOP_EN: keep cycling c11..c22 instead of blanking after c22.
module matrix_result_display #(
    parameter int DWELL_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        res_valid,
    input  logic [15:0] res_in,
    input  logic        err_in,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [1:0]  idx_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
    localparam logic [6:0]  SEG_BLANK  = 7'h00;
    localparam logic [6:0]  SEG_E      = 7'h79;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    logic [15:0] data;
    logic [15:0] data_next;

    logic [6:0]  seg_next;
    logic        dp_next;
    logic [1:0]  idx_out_next;
    logic        busy_next;
    logic [3:0]  elem;
    logic [3:0]  mag;

    function automatic logic [6:0] seg_decode(input logic [3:0] m);
        logic [6:0] s;
        case (m)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            idx     <= 2'd0;
            data    <= 16'd0;
            seg_out <= SEG_BLANK;
            dp_out  <= 1'b0;
            idx_out <= 2'd0;
            busy    <= 1'b0;
        end else if (ena) begin
            state   <= state_next;
            cnt     <= cnt_next;
            idx     <= idx_next;
            data    <= data_next;
            seg_out <= seg_next;
            dp_out  <= dp_next;
            idx_out <= idx_out_next;
            busy    <= busy_next;
        end
    end

    // A fresh capture outranks any dwell expiry in the same cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        data_next  = data;
        if (res_valid) begin
            data_next  = res_in;
            cnt_next   = 16'd0;
            idx_next   = 2'd0;
            state_next = err_in ? ERR : SHOW;
        end else begin
            case (state)
                SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        cnt_next = 16'd0;
                        if (idx == 2'd3) begin
`ifdef MRD_LOOP_EN
                            idx_next = 2'd0;
`else
                            idx_next   = 2'd0;
                            state_next = IDLE;
`endif
                        end else begin
                            idx_next = idx + 2'd1;
                        end
                    end else begin
                        cnt_next = cnt + 16'd1;
                    end
                end
                ERR: begin
                    if (cnt == DWELL_LAST) begin
                        cnt_next   = 16'd0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + 16'd1;
                    end
                end
                default: begin
                    cnt_next = 16'd0;
                    idx_next = 2'd0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the new display lands on the same edge.
    always_comb begin
        case (idx_next)
            2'd0:    elem = data_next[3:0];
            2'd1:    elem = data_next[7:4];
            2'd2:    elem = data_next[11:8];
            default: elem = data_next[15:12];
        endcase
        mag = elem[3] ? (~elem + 4'd1) : elem;

        seg_next     = SEG_BLANK;
        dp_next      = 1'b0;
        idx_out_next = 2'd0;
        busy_next    = 1'b0;
        case (state_next)
            SHOW: begin
                seg_next     = seg_decode(mag);
                dp_next      = elem[3];
                idx_out_next = idx_next;
                busy_next    = 1'b1;
            end
            ERR: begin
                seg_next  = SEG_E;
                busy_next = 1'b1;
            end
            default: begin
                seg_next = SEG_BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_result_display.sv
// tb/tb_matrix_result_display.sv - scoreboard bench for matrix_result_display with DWELL_CYCLES=4
module tb_matrix_result_display;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        res_valid;
    logic [15:0] res_in;
    logic        err_in;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [1:0]  idx_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    matrix_result_display #(.DWELL_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .res_valid (res_valid),
        .res_in    (res_in),
        .err_in    (err_in),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .idx_out   (idx_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-element display for res_in = 16'hE021: 1, 2, 0, -2
    logic [6:0] e021_seg[4];
    logic       e021_dp[4];
    initial begin
        e021_seg[0] = 7'h06; e021_dp[0] = 1'b0;
        e021_seg[1] = 7'h5B; e021_dp[1] = 1'b0;
        e021_seg[2] = 7'h3F; e021_dp[2] = 1'b0;
        e021_seg[3] = 7'h5B; e021_dp[3] = 1'b1;
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({seg_out, dp_out, idx_out, busy} !== e) begin
                errors++;
                $display("FAIL disp @%0t: got seg=%h dp=%b idx=%0d busy=%b, want seg=%h dp=%b idx=%0d busy=%b",
                         $time, seg_out, dp_out, idx_out, busy, e[10:4], e[3], e[2:1], e[0]);
            end
        end
    end

    task automatic tick(input logic e, input logic r, input logic v, input logic [15:0] d,
                        input logic er, input logic [6:0] s, input logic p,
                        input logic [1:0] i, input logic b);
        ena = e; rst_n = r; res_valid = v; res_in = d; err_in = er;
        @(posedge clk);
        exp_q.push_back({s, p, i, b});
        @(negedge clk);
    endtask

    task automatic idle_tick(input logic [6:0] s, input logic p, input logic [1:0] i, input logic b);
        tick(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, s, p, i, b);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        ena = 1'b0; rst_n = 1'b0; res_valid = 1'b0; res_in = 16'h0; err_in = 1'b0;
        @(negedge clk);
        // reset with ena low, then with ena high
        tick(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0);
        do_reset();
        idle_tick(7'h00, 1'b0, 2'd0, 1'b0);

        // full walk of 16'hE021
        tick(1'b1, 1'b1, 1'b1, 16'hE021, 1'b0, 7'h06, 1'b0, 2'd0, 1'b1);
        for (int k = 1; k < 16; k++)
            idle_tick(e021_seg[k/4], e021_dp[k/4], 2'(k/4), 1'b1);
`ifdef MRD_LOOP_EN
        for (int k = 0; k < 8; k++)
            idle_tick(e021_seg[k/4], e021_dp[k/4], 2'(k/4), 1'b1);
        do_reset();
`else
        for (int k = 0; k < 3; k++)
            idle_tick(7'h00, 1'b0, 2'd0, 1'b0);
`endif

        // error capture shows E for four cycles then blanks
        tick(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 7'h79, 1'b0, 2'd0, 1'b1);
        for (int k = 1; k < 4; k++)
            idle_tick(7'h79, 1'b0, 2'd0, 1'b1);
        idle_tick(7'h00, 1'b0, 2'd0, 1'b0);
        idle_tick(7'h00, 1'b0, 2'd0, 1'b0);

        // recapture while idx=2 restarts at c11 with a fresh dwell
        tick(1'b1, 1'b1, 1'b1, 16'hE021, 1'b0, 7'h06, 1'b0, 2'd0, 1'b1);
        for (int k = 1; k < 9; k++)
            idle_tick(e021_seg[k/4], e021_dp[k/4], 2'(k/4), 1'b1);
        tick(1'b1, 1'b1, 1'b1, 16'h0008, 1'b0, 7'h7F, 1'b1, 2'd0, 1'b1);
        for (int k = 1; k < 4; k++)
            idle_tick(7'h7F, 1'b1, 2'd0, 1'b1);
        idle_tick(7'h3F, 1'b0, 2'd1, 1'b1);
        idle_tick(7'h3F, 1'b0, 2'd1, 1'b1);

        // ena low for 10 cycles mid-dwell: frozen, capture ignored
        for (int k = 0; k < 10; k++)
            tick(1'b0, 1'b1, k[0], 16'hE021, 1'b0, 7'h3F, 1'b0, 2'd1, 1'b1);
        idle_tick(7'h3F, 1'b0, 2'd1, 1'b1);
        idle_tick(7'h3F, 1'b0, 2'd1, 1'b1);
        for (int k = 0; k < 4; k++)
            idle_tick(7'h3F, 1'b0, 2'd2, 1'b1);
        idle_tick(7'h3F, 1'b0, 2'd3, 1'b1);

        // reset mid-SHOW aborts and nothing is shown afterwards
        do_reset();
        idle_tick(7'h00, 1'b0, 2'd0, 1'b0);
        idle_tick(7'h00, 1'b0, 2'd0, 1'b0);

        // reset with ena low mid-SHOW
        tick(1'b1, 1'b1, 1'b1, 16'hE021, 1'b0, 7'h06, 1'b0, 2'd0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 7'h00, 1'b0, 2'd0, 1'b0);
        idle_tick(7'h00, 1'b0, 2'd0, 1'b0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
